// File: rtl/store_result_checker.sv
// rtl/store_result_checker.sv - result-store monitor with pass/fail/timeout verdict and store ring log
module store_result_checker #(
    parameter logic [31:0] TARGET_WORD      = 32'h0000002e,
    parameter logic [31:0] EXPECT_DATA      = 32'h6d73e55f,
    parameter int unsigned TIMEOUT_CYCLES   = 273,
    parameter int unsigned LOG_DEPTH        = 8,
    parameter bit          HALT_ON_MISMATCH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  status,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count,
    input  logic        log_rd_en,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_empty,
    output logic        log_full,
    output logic        log_overflow
);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(LOG_DEPTH);
    localparam logic [31:0]   LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_PASS    = 2'b01,
        S_FAIL    = 2'b10,
        S_TIMEOUT = 2'b11
    } state_t;

    state_t         state;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [31:0]    mem_addr [LOG_DEPTH];
    logic [31:0]    mem_data [LOG_DEPTH];

    logic running;
    logic store;
    logic target_hit;
    logic data_ok;
    logic full_now;
    logic pop;

    assign running    = (state == S_RUN);
    assign store      = running && memwrite;
    assign target_hit = (addr[31:2] == TARGET_WORD[29:0]);
    assign data_ok    = (writedata == EXPECT_DATA);
    assign full_now   = (count == DEPTH_C);
    assign pop        = log_rd_en && (count != '0);

    assign status    = state;
    assign log_empty = (count == '0);
    assign log_full  = full_now;

    // Verdict FSM; the deciding edge still counts its cycle and its store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            cycle_count <= '0;
            store_count <= '0;
        end else if (running) begin
            cycle_count <= cycle_count + 32'd1;
            if (store && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
            if (store && target_hit && data_ok) begin
                state <= S_PASS;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (store && target_hit && HALT_ON_MISMATCH) begin
                state <= S_FAIL;
                done  <= 1'b1;
            end else if (cycle_count == LAST_CYCLE) begin
                state <= S_TIMEOUT;
                done  <= 1'b1;
            end
        end
    end

    // Log pointers: a push into a full log drops the oldest entry unless a pop frees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            log_valid    <= 1'b0;
            log_addr     <= '0;
            log_data     <= '0;
            log_overflow <= 1'b0;
        end else begin
            log_valid <= pop;
            if (pop) begin
                log_addr <= mem_addr[rd_ptr];
                log_data <= mem_data[rd_ptr];
            end
            if (pop || (store && full_now))
                rd_ptr <= rd_ptr + PW'(1);
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (full_now && !pop)
                    log_overflow <= 1'b1;
            end
            if (store && !pop && !full_now)
                count <= count + CW'(1);
            else if (pop && !store)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_addr[wr_ptr] <= addr;
            mem_data[wr_ptr] <= writedata;
        end
    end

endmodule

// File: tb/tb_store_result_checker.sv
// tb/tb_store_result_checker.sv - randomized self-checking bench for store_result_checker
module tb_store_result_checker;
    localparam logic [31:0] TARGET_WORD    = 32'h0000002e;
    localparam logic [31:0] EXPECT_DATA    = 32'h6d73e55f;
    localparam int unsigned TIMEOUT_CYCLES = 273;
    localparam int unsigned LOG_DEPTH      = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic        log_rd_en = 1'b0;

    logic        done_h, pass_h, log_valid_h, log_empty_h, log_full_h, log_overflow_h;
    logic [1:0]  status_h;
    logic [31:0] cycle_count_h, log_addr_h, log_data_h;
    logic [15:0] store_count_h;
    logic        done_n, pass_n, log_valid_n, log_empty_n, log_full_n, log_overflow_n;
    logic [1:0]  status_n;
    logic [31:0] cycle_count_n, log_addr_n, log_data_n;
    logic [15:0] store_count_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_result_checker #(
        .TARGET_WORD(TARGET_WORD), .EXPECT_DATA(EXPECT_DATA), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LOG_DEPTH(LOG_DEPTH), .HALT_ON_MISMATCH(1'b1)
    ) dut_h (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
        .done(done_h), .pass(pass_h), .status(status_h), .cycle_count(cycle_count_h),
        .store_count(store_count_h), .log_rd_en(log_rd_en), .log_valid(log_valid_h),
        .log_addr(log_addr_h), .log_data(log_data_h), .log_empty(log_empty_h),
        .log_full(log_full_h), .log_overflow(log_overflow_h)
    );

    store_result_checker #(
        .TARGET_WORD(TARGET_WORD), .EXPECT_DATA(EXPECT_DATA), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LOG_DEPTH(LOG_DEPTH), .HALT_ON_MISMATCH(1'b0)
    ) dut_n (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
        .done(done_n), .pass(pass_n), .status(status_n), .cycle_count(cycle_count_n),
        .store_count(store_count_n), .log_rd_en(log_rd_en), .log_valid(log_valid_n),
        .log_addr(log_addr_n), .log_data(log_data_n), .log_empty(log_empty_n),
        .log_full(log_full_n), .log_overflow(log_overflow_n)
    );

    // Reference model: index 0 halts on mismatch, index 1 ignores it; log modelled for index 0.
    int          m_st [2];
    int unsigned m_cyc [2];
    int unsigned m_stc [2];
    logic [63:0] m_q [$];
    bit          m_ovf;
    bit          m_valid;
    logic [63:0] m_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i]  = 0;
            m_cyc[i] = 0;
            m_stc[i] = 0;
        end
        m_q.delete();
        m_ovf   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit hit;
        m_valid = 1'b0;
        if (log_rd_en && m_q.size() > 0) begin
            m_pop   = m_q.pop_front();
            m_valid = 1'b1;
        end
        hit = memwrite && ((addr >> 2) == TARGET_WORD);
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 0) begin
                if (memwrite) m_stc[i] = (m_stc[i] == 65535) ? 65535 : m_stc[i] + 1;
                if (i == 0 && memwrite) begin
                    m_q.push_back({addr, writedata});
                    if (m_q.size() > LOG_DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                if (hit && writedata == EXPECT_DATA) m_st[i] = 1;
                else if (hit && i == 0)             m_st[i] = 2;
                else if (m_cyc[i] == TIMEOUT_CYCLES - 1) m_st[i] = 3;
                m_cyc[i]++;
            end
        end
    endtask

    task automatic compare_all();
        check("status_h", status_h, m_st[0]);
        check("done_h", done_h, m_st[0] != 0);
        check("pass_h", pass_h, m_st[0] == 1);
        check("cycles_h", cycle_count_h, m_cyc[0]);
        check("stores_h", store_count_h, m_stc[0]);
        check("status_n", status_n, m_st[1]);
        check("cycles_n", cycle_count_n, m_cyc[1]);
        check("stores_n", store_count_n, m_stc[1]);
        check("log_valid", log_valid_h, m_valid);
        if (m_valid) begin
            check("log_addr", log_addr_h, m_pop[63:32]);
            check("log_data", log_data_h, m_pop[31:0]);
        end
        check("log_empty", log_empty_h, m_q.size() == 0);
        check("log_full", log_full_h, m_q.size() == LOG_DEPTH);
        check("log_overflow", log_overflow_h, m_ovf);
    endtask

    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rd);
        memwrite  = we;
        addr      = a;
        writedata = d;
        log_rd_en = rd;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        memwrite  = 1'b0;
        log_rd_en = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_status", status_h, 2'b00);
        check("rst_empty", log_empty_h, 1'b1);
        check("rst_cycles", cycle_count_h, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] non_target();
        logic [31:0] a;
        a = $urandom;
        if ((a >> 2) == TARGET_WORD) a = a ^ 32'h100;
        return a;
    endfunction

    initial begin
        apply_reset();

        // Result store after five ordinary stores.
        for (int w = 16; w <= 20; w++) step(1'b1, 32'(w * 4), $urandom, 1'b0);
        step(1'b1, 32'h000000B8, EXPECT_DATA, 1'b0);
        check("pass_status", status_h, 2'b01);
        check("pass_flag", pass_h, 1'b1);
        check("pass_stores", store_count_h, 16'd6);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0);
        check("pass_frozen", cycle_count_h, 32'd6);
        repeat (8) step(1'b1, non_target(), $urandom, 1'b1);
        check("drain_empty", log_empty_h, 1'b1);

        // Wrong data at the target word.
        apply_reset();
        repeat (3) step(1'b1, non_target(), $urandom, 1'b0);
        step(1'b1, 32'h000000BA, 32'h0, 1'b0);
        check("fail_status", status_h, 2'b10);
        check("fail_pass", pass_h, 1'b0);
        check("nohalt_status", status_n, 2'b00);
        check("nohalt_stores", store_count_n, 16'd4);

        // Timeout with random traffic and pops.
        apply_reset();
        repeat (272) step(1'($urandom_range(0, 1)), non_target(), $urandom, $urandom_range(0, 3) == 0);
        check("pre_timeout", status_h, 2'b00);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("timeout_status", status_h, 2'b11);
        check("timeout_cycles", cycle_count_h, 32'd273);
        repeat (4) step(1'b1, non_target(), $urandom, 1'b0);
        check("timeout_frozen", cycle_count_h, 32'd273);

        // Correct result store on the timeout edge wins.
        apply_reset();
        repeat (272) step(1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h000000B8, EXPECT_DATA, 1'b0);
        check("edge_pass", status_h, 2'b01);
        check("edge_cycles", cycle_count_h, 32'd273);

        // Ten stores into an eight-entry log.
        apply_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 32'h1000 + 32'(k * 4), 32'(k), 1'b0);
        check("ovf_full", log_full_h, 1'b1);
        check("ovf_flag", log_overflow_h, 1'b1);
        for (int k = 3; k <= 10; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1);
            check("pop_valid", log_valid_h, 1'b1);
            check("pop_addr", log_addr_h, 32'h1000 + 32'(k * 4));
            check("pop_data", log_data_h, 32'(k));
        end
        check("pop_empty", log_empty_h, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("pop_on_empty", log_valid_h, 1'b0);

        // Push and pop together on a full log.
        apply_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 32'h2000 + 32'(k * 4), 32'(100 + k), 1'b0);
        step(1'b1, 32'h3000, 32'h55, 1'b1);
        check("pp_valid", log_valid_h, 1'b1);
        check("pp_head", log_addr_h, 32'h2000);
        check("pp_full", log_full_h, 1'b1);
        check("pp_no_ovf", log_overflow_h, 1'b0);

        // Reset in the middle of a run.
        apply_reset();
        repeat (5) step(1'b1, non_target(), $urandom, 1'b0);
        apply_reset();
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("restart_cycles", cycle_count_h, 32'd1);

        // Random traffic with occasional result stores.
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 39) == 0)
                    step(1'b1, {TARGET_WORD[29:0], 2'($urandom)},
                         ($urandom_range(0, 1) == 0) ? EXPECT_DATA : $urandom, $urandom_range(0, 2) == 0);
                else
                    step(1'($urandom_range(0, 1)), non_target(), $urandom, $urandom_range(0, 2) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
